// File: rtl/selector_2i_ctrl.sv
// Frame-safe select controller for the 2-input frame selector: moves sel only between frames,
// with optional auto-alternation every N frames and a stall watchdog that releases dead frames.
//
// state | meaning
// IDLE  | no frame open; sel may change on any edge
// FRAME | sof accepted, waiting for eof (or watchdog expiry); sel frozen
module selector_2i_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8,
    parameter int TIMEOUT     = 0,
    parameter int TO_WIDTH    = 24,
    parameter bit SEL_RST     = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sel_req,
    input  logic                 auto_en,
    input  logic [CNT_WIDTH-1:0] auto_frames,
    input  logic                 out_frm_val,
    input  logic                 out_frm_rdy,
    input  logic                 out_frm_sof,
    input  logic                 out_frm_eof,
    output logic                 sel,
    output logic                 in_frame,
    output logic                 sel_pending,
    output logic                 frm_done,
    output logic                 frm_abort,
    output logic [CNT_WIDTH-1:0] frm_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    localparam bit                WD_ON   = (TIMEOUT > 0);
    localparam logic [TO_WIDTH-1:0] WD_LOAD = WD_ON ? TO_WIDTH'(TIMEOUT - 1) : '0;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   beat;
    logic                   complete;
    logic                   abort;
    logic                   wd_hit;
    logic [TO_WIDTH-1:0]    wd_cnt;
    logic [CNT_WIDTH-1:0]   auto_cnt;
    logic [CNT_WIDTH-1:0]   auto_cnt_nxt;
    logic [CNT_WIDTH-1:0]   auto_last;
    logic                   sel_nxt;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        beat      = out_frm_val & out_frm_rdy;
        wd_hit    = WD_ON && (state == FRAME) && !beat && (wd_cnt == '0);
        state_nxt = state;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                // a sof&eof beat is a whole 1-beat frame; non-sof beats are strays
                if (beat && out_frm_sof) begin
                    if (out_frm_eof) complete = 1'b1;
                    else             state_nxt = FRAME;
                end
            end
            FRAME: begin
                if (beat && out_frm_eof) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else if (wd_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        auto_last    = (auto_frames == '0) ? '0 : auto_frames - CNT_WIDTH'(1);
        sel_nxt      = sel;
        auto_cnt_nxt = auto_cnt;
        if (auto_en) begin
            // completions only happen on edges that leave us idle, so the flip is frame-safe
            if (complete) begin
                if (auto_cnt == auto_last) begin
                    auto_cnt_nxt = '0;
                    sel_nxt      = ~sel;
                end else begin
                    auto_cnt_nxt = auto_cnt + CNT_WIDTH'(1);
                end
            end
        end else begin
            auto_cnt_nxt = '0;
            if (state_nxt == IDLE) sel_nxt = req_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sync_q      <= {SYNC_STAGES{SEL_RST}};
            sel         <= SEL_RST;
            in_frame    <= 1'b0;
            sel_pending <= 1'b0;
            frm_done    <= 1'b0;
            frm_abort   <= 1'b0;
            frm_cnt     <= '0;
            auto_cnt    <= '0;
            wd_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], sel_req};
            sel         <= sel_nxt;
            in_frame    <= (state_nxt == FRAME);
            // compare the values req_s and sel will hold after this edge
            sel_pending <= ~auto_en & (sync_q[SYNC_STAGES-2] != sel_nxt);
            frm_done    <= complete;
            frm_abort   <= abort;
            frm_cnt     <= frm_cnt + CNT_WIDTH'(complete);
            auto_cnt    <= auto_cnt_nxt;
            if (state == IDLE || beat) begin
                wd_cnt <= WD_LOAD;
            end else if (wd_cnt != '0) begin
                wd_cnt <= wd_cnt - TO_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_selector_2i_ctrl.sv
// Bench for selector_2i_ctrl: frame-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_selector_2i_ctrl;

    localparam int SYNC = 2;
    localparam int CW   = 8;
    localparam int TO   = 100;
    localparam bit SRST = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          sel_req = 1'b0;
    logic          auto_en = 1'b0;
    logic [CW-1:0] auto_frames = '0;
    logic          val = 1'b0;
    logic          rdy = 1'b0;
    logic          sof = 1'b0;
    logic          eof = 1'b0;
    logic          sel;
    logic          in_frame;
    logic          sel_pending;
    logic          frm_done;
    logic          frm_abort;
    logic [CW-1:0] frm_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int done_pulses = 0;

    selector_2i_ctrl #(
        .SYNC_STAGES(SYNC),
        .CNT_WIDTH  (CW),
        .TIMEOUT    (TO),
        .TO_WIDTH   (24),
        .SEL_RST    (SRST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_req    (sel_req),
        .auto_en    (auto_en),
        .auto_frames(auto_frames),
        .out_frm_val(val),
        .out_frm_rdy(rdy),
        .out_frm_sof(sof),
        .out_frm_eof(eof),
        .sel        (sel),
        .in_frame   (in_frame),
        .sel_pending(sel_pending),
        .frm_done   (frm_done),
        .frm_abort  (frm_abort),
        .frm_cnt    (frm_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks whether a frame is open, how long it has stalled, the
    // request as seen after SYNC flops, and frames delivered since the last auto switch.
    bit m_sel, m_in_frame, m_pending, m_done, m_abort;
    int m_cnt, m_stall, m_auto;
    bit m_hist[SYNC];
    bit b, completed, aborted, next_in, req_old;
    int lim;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sel = SRST; m_in_frame = 0; m_pending = 0; m_done = 0; m_abort = 0;
            m_cnt = 0; m_stall = 0; m_auto = 0;
            for (int i = 0; i < SYNC; i++) m_hist[i] = SRST;
        end else begin
            b = val & rdy;
            completed = 0; aborted = 0; next_in = m_in_frame;
            if (!m_in_frame) begin
                if (b && sof) begin
                    if (eof) completed = 1;
                    else begin next_in = 1; m_stall = 0; end
                end
            end else if (b) begin
                m_stall = 0;
                if (eof) begin completed = 1; next_in = 0; end
            end else begin
                m_stall++;
                if (TO > 0 && m_stall >= TO) begin aborted = 1; next_in = 0; end
            end
            req_old = m_hist[SYNC-1];
            for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = sel_req;
            if (auto_en) begin
                lim = (auto_frames == 0) ? 1 : int'(auto_frames);
                if (completed) begin
                    if (m_auto == lim - 1) begin m_auto = 0; m_sel = !m_sel; end
                    else m_auto++;
                end
            end else begin
                m_auto = 0;
                if (!next_in) m_sel = req_old;
            end
            m_pending  = !auto_en && (m_hist[SYNC-1] != m_sel);
            m_done     = completed;
            m_abort    = aborted;
            m_cnt      = (m_cnt + int'(completed)) % (1 << CW);
            m_in_frame = next_in;
        end
    end

    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            check("m_sel", sel, m_sel);
            check("m_in_frame", in_frame, m_in_frame);
            check("m_sel_pending", sel_pending, m_pending);
            check("m_frm_done", frm_done, m_done);
            check("m_frm_abort", frm_abort, m_abort);
            check("m_frm_cnt", frm_cnt, m_cnt[CW-1:0]);
            if (frm_done) done_pulses++;
        end
    end

    task automatic send_frame(input int n, output logic s0);
        int bi = 0;
        int cyc = 0;
        s0 = 1'b0;
        while (bi < n && cyc < 400) begin
            val = 1'b1;
            sof = (bi == 0);
            eof = (bi == n - 1);
            rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (rdy) begin
                if (bi == 0) s0 = sel;
                bi++;
            end
            cyc++;
        end
        if (bi < n) check("t4_frame_timeout", bi, n);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    logic exp_sel[6] = '{0, 0, 1, 1, 0, 0};
    logic s0;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_sel", sel, 1);
        check("rst_in_frame", in_frame, 0);
        check("rst_cnt", frm_cnt, 0);
        check("rst_done", frm_done, 0);
        check("rst_abort", frm_abort, 0);
        rst_n = 1'b1;
        @(negedge clk); check("post_rst_sel_e1", sel, 1);
        @(negedge clk); check("post_rst_sel_e2", sel, 1);
        @(negedge clk); check("post_rst_sel_e3", sel, 0);
        repeat (2) @(negedge clk);

        // idle switch: SYNC+1 edges
        sel_req = 1'b1;
        @(negedge clk); check("t3_sel_e1", sel, 0);
        @(negedge clk); check("t3_sel_e2", sel, 0); check("t3_pend_e2", sel_pending, 1);
        @(negedge clk); check("t3_sel_e3", sel, 1); check("t3_pend_e3", sel_pending, 0);
        sel_req = 1'b0;
        repeat (4) @(negedge clk);
        check("t2_sel_start", sel, 0);

        // manual request mid-frame, 16-beat frame
        for (int k = 0; k < 16; k++) begin
            val = 1'b1; rdy = 1'b1; sof = (k == 0); eof = (k == 15);
            if (k == 1) sel_req = 1'b1;
            @(negedge clk);
            if (k < 15) begin
                check("t2_sel_hold", sel, 0);
                check("t2_in_frame", in_frame, 1);
            end
            if (k == 4) check("t2_pending", sel_pending, 1);
            if (k == 15) begin
                check("t2_sel_eof", sel, 1);
                check("t2_in_frame_eof", in_frame, 0);
                check("t2_done", frm_done, 1);
                check("t2_pend_eof", sel_pending, 0);
            end
        end
        val = 1'b0; sof = 1'b0; eof = 1'b0;
        @(negedge clk); check("t2_done_end", frm_done, 0); check("t2_cnt", frm_cnt, 1);

        // edge beats
        val = 1'b1; rdy = 1'b1; sof = 1'b1; eof = 1'b1;
        @(negedge clk);
        check("t6_1beat_done", frm_done, 1); check("t6_1beat_idle", in_frame, 0);
        check("t6_1beat_cnt", frm_cnt, 2);
        sof = 1'b0; eof = 1'b0;
        @(negedge clk); check("t6_stray_idle", in_frame, 0); check("t6_stray_done", frm_done, 0);
        eof = 1'b1;
        @(negedge clk); check("t6_stray_eof_done", frm_done, 0); check("t6_stray_eof_cnt", frm_cnt, 2);
        sof = 1'b1; eof = 1'b0;
        @(negedge clk); check("t6_open", in_frame, 1);
        @(negedge clk); check("t6_restart_frame", in_frame, 1); check("t6_restart_done", frm_done, 0);
        sof = 1'b0; eof = 1'b1; rdy = 1'b0;
        @(negedge clk); check("t6_norhdy_frame", in_frame, 1); check("t6_nordy_done", frm_done, 0);
        rdy = 1'b1;
        @(negedge clk); check("t6_close_done", frm_done, 1); check("t6_close_cnt", frm_cnt, 3);
        val = 1'b0; sof = 1'b0; eof = 1'b0;
        @(negedge clk);

        // watchdog
        val = 1'b1; rdy = 1'b1; sof = 1'b1;
        @(negedge clk); check("t5_open", in_frame, 1);
        val = 1'b0; sof = 1'b0;
        for (int k = 1; k <= 101; k++) begin
            if (k == 1) sel_req = 1'b0;
            @(negedge clk);
            if (k == 99) begin
                check("t5_abort_early", frm_abort, 0); check("t5_frame_99", in_frame, 1);
                check("t5_sel_99", sel, 1); check("t5_pend_99", sel_pending, 1);
            end
            if (k == 100) begin
                check("t5_abort", frm_abort, 1); check("t5_idle", in_frame, 0);
                check("t5_sel_abort", sel, 0); check("t5_cnt", frm_cnt, 3);
                check("t5_no_done", frm_done, 0);
            end
            if (k == 101) check("t5_abort_pulse", frm_abort, 0);
        end

        // reset mid-frame
        val = 1'b1; rdy = 1'b1; sof = 1'b1;
        @(negedge clk); sof = 1'b0;
        @(negedge clk); check("t1_pre_frame", in_frame, 1); check("t1_pre_sel", sel, 0);
        sof = 1'b1; eof = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t1_sel", sel, 1); check("t1_in_frame", in_frame, 0); check("t1_cnt", frm_cnt, 0);
        check("t1_done", frm_done, 0); check("t1_abort", frm_abort, 0);
        repeat (2) @(negedge clk);
        check("t1_done_in_rst", frm_done, 0); check("t1_cnt_in_rst", frm_cnt, 0);
        val = 1'b0; sof = 1'b0; eof = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); check("t1_done_after", frm_done, 0); check("t1_abort_after", frm_abort, 0);
        check("t1_sel_after", sel, 1);
        repeat (4) @(negedge clk);
        check("t4_sel_start", sel, 0);

        // auto alternation with random backpressure
        auto_frames = 8'd2; auto_en = 1'b1;
        @(negedge clk);
        done_pulses = 0;
        for (int f = 0; f < 6; f++) begin
            send_frame(16, s0);
            check("t4_sel_frame", s0, exp_sel[f]);
        end
        val = 1'b0; sof = 1'b0; eof = 1'b0; rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_cnt", frm_cnt, 6);
        check("t4_done_pulses", done_pulses, 6);
        check("t4_pending", sel_pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
